alu_secuencial: RTL and testbench
=================================

# alu_secuencial

Sequential execution unit that consumes the 4-bit ALU operation code and the 3-bit branch-condition code produced by the ALU control decoder. It computes the result and the branch decision for the multi-cycle datapath. Operands are accepted through a valid/ready handshake. Shifts run iteratively, one bit per cycle, unless the fast-shift option is compiled in. Results are held under an output valid/ready handshake until the datapath takes them.

## Interface
- ANCHO, 32, operand/result width; shift amount is B[$clog2(ANCHO)-1:0]
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  reset, synchronous, active-high
- valid_i  input  1  operands/codes present
- ready_o  output  1  unit can accept; high only in IDLE
- aluoperacion_i  input  4  operation code (encoding below)
- branch_i  input  1  instruction is a branch; qualifies branch_ctrl_i
- branch_ctrl_i  input  3  branch condition code
- a_i  input  ANCHO  operand A
- b_i  input  ANCHO  operand B / shift amount
- valid_o  output  1  result valid, held until accepted
- ready_i  input  1  consumer accepts result
- resultado_o  output  ANCHO  result
- zero_o  output  1  resultado_o == 0
- taken_o  output  1  branch taken (0 when branch_i was 0)
- error_o  output  1  unsupported operation code was accepted

## Operation
- Operation codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 SUB
  - 0100 XOR, 0101 SLT (signed), 0110 SLTU
  - 1001 SLL, 1010 SRL, 1011 SRA
  - any other code (incl. 1111) is unsupported
- Arithmetic:
  - ADD and SUB wrap modulo 2^ANCHO; no carry or overflow output.
  - SLT and SLTU return 1 or 0 zero-extended to ANCHO.
- Unsupported code: resultado_o=0, zero_o=1, taken_o=0, error_o=1 for that result.
- Branch decision (taken_o), computed from the final result when branch_i=1:
  - 000 BEQ: zero
  - 001 BNE: !zero
  - 100 BLT: result[0]
  - 101 BGE: !result[0]
  - 110 BLTU: result[0]
  - 111 BGEU: !result[0]
  - 010 and 011: taken_o=0.
- Operands, codes and the branch flag are latched on acceptance (valid_i & ready_o). Later input changes have no effect on an in-flight operation.
- FSM states:
  - IDLE: ready_o=1. On accept, a non-shift or unsupported op goes to DONE. A shift with shamt=0 goes to DONE with result = A. A shift with shamt>0 goes to SHIFT with the counter loaded with shamt.
  - SHIFT: each cycle shifts the working register one bit (SLL: insert 0 at LSB; SRL: insert 0 at MSB; SRA: replicate MSB) and decrements the counter. When the counter reaches 1, the last shift is performed and the FSM goes to DONE.
  - DONE: valid_o=1 and all outputs stable. On ready_i, go to IDLE.

## Timing
- Reset: state IDLE, ready_o=1, valid_o=0, resultado_o=0, zero_o=1, taken_o=0, error_o=0. Any in-flight operation is discarded; rst_i takes priority over all handshakes.
- Latency is measured from the accept edge N:
  - non-shift op: valid_o high from edge N+1
  - shift: valid_o high from edge N+1+shamt
  - shamt=ANCHO-1 (31 at default): valid_o at N+32
- Output backpressure: valid_o and all result outputs are held unchanged while ready_i=0.
- Handoff and restart: a handoff at edge M returns the FSM to IDLE, so the earliest next accept is edge M+1. valid_i during DONE or SHIFT is ignored (ready_o=0).
- valid_o with ready_i at the same edge: the result is consumed and valid_o falls after that edge.
- Throughput: one non-shift op every 2 cycles with ready_i held high.

## Configuration
- ALU_SHIFT_RAPIDO_EN defined:
  - Shifts use a combinational barrel shifter and go straight from IDLE to DONE.
  - Every op then has latency 1 and the SHIFT state is not built.
- ALU_SHIFT_RAPIDO_EN not defined: the iterative shifter above is used, with latency shamt+1.
- Results are bit-identical in both builds.

## Test plan
- Reset, then ADD a=0xFFFFFFFF b=0x00000002 -> resultado_o=0x00000001, valid_o at N+1, zero_o=0. SUB a=5 b=5 -> resultado_o=0, zero_o=1.
- SRA a=0x80000000 b=31, iterative build -> valid_o at N+32, resultado_o=0xFFFFFFFF. SRL with the same operands -> 0x00000001. SLL b=0 -> resultado_o=a at N+1.
- Branches:
  - XOR with branch_i=1, ctrl=000, a=b=7 -> taken_o=1.
  - SLT with ctrl=100, a=0xFFFFFFFF (-1), b=1 -> taken_o=1.
  - SLTU with ctrl=110 and the same operands -> taken_o=0.
- Backpressure: hold ready_i=0 for 5 cycles after valid_o -> outputs stable and ready_o=0; pulse valid_i with new operands meanwhile -> ignored. Release ready_i -> ready_o=1 next cycle.
- Unsupported code 1111 -> error_o=1, resultado_o=0, taken_o=0. Next ADD -> error_o=0.
- Assert rst_i during SHIFT at cycle 10 of a 20-bit shift -> next cycle IDLE, valid_o=0, ready_o=1, and no stale result appears afterwards.

Source files
------------

// File: rtl/alu_secuencial_if.sv
// alu_secuencial_if: operand/result valid-ready bundle for alu_secuencial; master drives operands and ready_i, slave returns result/flags
interface alu_secuencial_if #(parameter int ANCHO = 32);
  logic             valid_i;
  logic             ready_o;
  logic [3:0]       aluoperacion_i;
  logic             branch_i;
  logic [2:0]       branch_ctrl_i;
  logic [ANCHO-1:0] a_i;
  logic [ANCHO-1:0] b_i;
  logic             valid_o;
  logic             ready_i;
  logic [ANCHO-1:0] resultado_o;
  logic             zero_o;
  logic             taken_o;
  logic             error_o;
  modport master (
    output valid_i, aluoperacion_i, branch_i, branch_ctrl_i, a_i, b_i, ready_i,
    input  ready_o, valid_o, resultado_o, zero_o, taken_o, error_o
  );
  modport slave (
    input  valid_i, aluoperacion_i, branch_i, branch_ctrl_i, a_i, b_i, ready_i,
    output ready_o, valid_o, resultado_o, zero_o, taken_o, error_o
  );
endinterface

// File: rtl/alu_secuencial.sv
// alu_secuencial: multi-cycle ALU + branch decision; ports clk_i, rst_i (sync, active-high), bus (alu_secuencial_if.slave); define ALU_SHIFT_RAPIDO_EN for a single-cycle barrel shifter
module alu_secuencial #(
  parameter int ANCHO = 32
) (
  input logic             clk_i,
  input logic             rst_i,
  alu_secuencial_if.slave bus
);
  localparam int SW = $clog2(ANCHO);
`ifdef ALU_SHIFT_RAPIDO_EN
  typedef enum logic {IDLE, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif
  state_t           r_state, w_next;
  logic [ANCHO-1:0] r_res, w_alu, w_fin;
  logic             r_zero, r_taken, r_err;
  logic             w_acc, w_unsup, w_err, w_fin_en, w_br, w_zero, w_taken;
  logic [2:0]       w_ctrl;
  logic [SW-1:0]    w_shamt;
  assign w_acc   = bus.valid_i && r_state == IDLE;
  assign w_shamt = bus.b_i[SW-1:0];
  always_comb begin
    w_unsup = 1'b0;
    case (bus.aluoperacion_i)
      4'b0000: w_alu = bus.a_i & bus.b_i;
      4'b0001: w_alu = bus.a_i | bus.b_i;
      4'b0010: w_alu = bus.a_i + bus.b_i;
      4'b0011: w_alu = bus.a_i - bus.b_i;
      4'b0100: w_alu = bus.a_i ^ bus.b_i;
      4'b0101: w_alu = ANCHO'($signed(bus.a_i) < $signed(bus.b_i));
      4'b0110: w_alu = ANCHO'(bus.a_i < bus.b_i);
`ifdef ALU_SHIFT_RAPIDO_EN
      4'b1001: w_alu = bus.a_i << w_shamt;
      4'b1010: w_alu = bus.a_i >> w_shamt;
      4'b1011: w_alu = $unsigned($signed(bus.a_i) >>> w_shamt);
`else
      4'b1001, 4'b1010, 4'b1011: w_alu = bus.a_i;
`endif
      default: begin
        w_alu   = '0;
        w_unsup = 1'b1;
      end
    endcase
  end
`ifdef ALU_SHIFT_RAPIDO_EN
  assign w_fin    = w_alu;
  assign w_fin_en = w_acc;
  assign w_br     = bus.branch_i;
  assign w_ctrl   = bus.branch_ctrl_i;
  assign w_err    = w_unsup;
`else
  logic [ANCHO-1:0] r_w, w_step;
  logic [SW-1:0]    r_cnt;
  logic [1:0]       r_sh;
  logic [2:0]       r_ctrl;
  logic             r_br, w_go, w_last;
  // r_sh holds op[1:0]: 01 SLL, 10 SRL, 11 SRA (bit 0 selects sign fill on right shifts)
  assign w_step   = r_sh == 2'b01 ? {r_w[ANCHO-2:0], 1'b0} : {r_sh[0] & r_w[ANCHO-1], r_w[ANCHO-1:1]};
  assign w_go     = w_acc && bus.aluoperacion_i inside {4'b1001, 4'b1010, 4'b1011} && w_shamt != '0;
  assign w_last   = r_state == SHIFT && r_cnt == SW'(1);
  assign w_fin    = w_last ? w_step : w_alu;
  assign w_fin_en = (w_acc && !w_go) || w_last;
  assign w_br     = w_last ? r_br : bus.branch_i;
  assign w_ctrl   = w_last ? r_ctrl : bus.branch_ctrl_i;
  assign w_err    = !w_last && w_unsup;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_w    <= '0;
      r_cnt  <= '0;
      r_sh   <= '0;
      r_br   <= 1'b0;
      r_ctrl <= '0;
    end else if (w_acc) begin
      r_w    <= bus.a_i;
      r_cnt  <= w_shamt;
      r_sh   <= bus.aluoperacion_i[1:0];
      r_br   <= bus.branch_i;
      r_ctrl <= bus.branch_ctrl_i;
    end else if (r_state == SHIFT) begin
      r_w   <= w_step;
      r_cnt <= r_cnt - SW'(1);
    end
  end
`endif
  assign w_zero  = w_fin == '0;
  // ctrl[2]: compare ops read result[0]; else 00x tests zero; ctrl[0] inverts; 01x never taken
  assign w_taken = !w_br || w_err ? 1'b0 :
                   w_ctrl[2] ? w_fin[0] ^ w_ctrl[0] :
                   w_ctrl[1] ? 1'b0 : w_zero ^ w_ctrl[0];
  always_comb begin
    w_next = r_state;
    case (r_state)
`ifdef ALU_SHIFT_RAPIDO_EN
      IDLE:    w_next = w_acc ? DONE : IDLE;
`else
      IDLE:    w_next = w_acc ? (w_go ? SHIFT : DONE) : IDLE;
      SHIFT:   w_next = w_last ? DONE : SHIFT;
`endif
      default: w_next = bus.ready_i ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_res   <= '0;
      r_zero  <= 1'b1;
      r_taken <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_fin_en) begin
      r_res   <= w_fin;
      r_zero  <= w_zero;
      r_taken <= w_taken;
      r_err   <= w_err;
    end
  end
  assign bus.ready_o     = r_state == IDLE;
  assign bus.valid_o     = r_state == DONE;
  assign bus.resultado_o = r_res;
  assign bus.zero_o      = r_zero;
  assign bus.taken_o     = r_taken;
  assign bus.error_o     = r_err;
endmodule

// File: tb/tb_alu_secuencial.sv
// tb_alu_secuencial: directed self-checking bench for alu_secuencial (iterative-shift build)
module tb_alu_secuencial;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   lat;
  int   bad;
  alu_secuencial_if #(.ANCHO(32)) bus ();
  alu_secuencial #(.ANCHO(32)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );
  always #5 clk_i = ~clk_i;
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic [3:0] op, input logic br, input logic [2:0] ctrl,
                     input logic [31:0] a, input logic [31:0] b, output int n);
    bus.valid_i        = 1'b1;
    bus.aluoperacion_i = op;
    bus.branch_i       = br;
    bus.branch_ctrl_i  = ctrl;
    bus.a_i            = a;
    bus.b_i            = b;
    tick();
    bus.valid_i        = 1'b0;
    bus.aluoperacion_i = 4'($urandom);
    bus.branch_i       = 1'($urandom);
    bus.branch_ctrl_i  = 3'($urandom);
    bus.a_i            = $urandom;
    bus.b_i            = $urandom;
    n = 0;
    while (!bus.valid_o && n < 100) begin
      tick();
      n++;
    end
  endtask
  task automatic handoff(input string tag);
    bus.ready_i = 1'b1;
    tick();
    bus.ready_i = 1'b0;
    chk({tag, "_valid_low"}, 32'(bus.valid_o), 32'd0);
    chk({tag, "_ready_high"}, 32'(bus.ready_o), 32'd1);
  endtask
  initial begin
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.aluoperacion_i = '0;
    bus.branch_i = 1'b0;
    bus.branch_ctrl_i = '0;
    bus.a_i = '0;
    bus.b_i = '0;
    tick();
    tick();
    chk("rst_ready", 32'(bus.ready_o), 32'd1);
    chk("rst_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_res", bus.resultado_o, 32'd0);
    chk("rst_zero", 32'(bus.zero_o), 32'd1);
    chk("rst_taken", 32'(bus.taken_o), 32'd0);
    chk("rst_err", 32'(bus.error_o), 32'd0);
    rst_i = 1'b0;
    run(4'b0010, 1'b0, 3'b000, 32'hFFFF_FFFF, 32'h2, lat);
    chk("add_lat", 32'(lat), 32'd0);
    chk("add_res", bus.resultado_o, 32'h1);
    chk("add_zero", 32'(bus.zero_o), 32'd0);
    handoff("add");
    run(4'b0011, 1'b0, 3'b000, 32'd5, 32'd5, lat);
    chk("sub_res", bus.resultado_o, 32'h0);
    chk("sub_zero", 32'(bus.zero_o), 32'd1);
    handoff("sub");
    run(4'b1011, 1'b0, 3'b000, 32'h8000_0000, 32'd31, lat);
    chk("sra_lat", 32'(lat), 32'd31);
    chk("sra_res", bus.resultado_o, 32'hFFFF_FFFF);
    handoff("sra");
    run(4'b1010, 1'b0, 3'b000, 32'h8000_0000, 32'd31, lat);
    chk("srl_lat", 32'(lat), 32'd31);
    chk("srl_res", bus.resultado_o, 32'h1);
    handoff("srl");
    run(4'b1001, 1'b0, 3'b000, 32'h0000_1234, 32'd0, lat);
    chk("sll0_lat", 32'(lat), 32'd0);
    chk("sll0_res", bus.resultado_o, 32'h1234);
    handoff("sll0");
    run(4'b1001, 1'b0, 3'b000, 32'h3, 32'hFFFF_FFE4, lat);
    chk("sll4_lat", 32'(lat), 32'd4);
    chk("sll4_res", bus.resultado_o, 32'h30);
    handoff("sll4");
    run(4'b0100, 1'b1, 3'b000, 32'd7, 32'd7, lat);
    chk("beq_res", bus.resultado_o, 32'h0);
    chk("beq_taken", 32'(bus.taken_o), 32'd1);
    handoff("beq");
    run(4'b0101, 1'b1, 3'b100, 32'hFFFF_FFFF, 32'd1, lat);
    chk("blt_res", bus.resultado_o, 32'h1);
    chk("blt_taken", 32'(bus.taken_o), 32'd1);
    handoff("blt");
    run(4'b0110, 1'b1, 3'b110, 32'hFFFF_FFFF, 32'd1, lat);
    chk("bltu_res", bus.resultado_o, 32'h0);
    chk("bltu_taken", 32'(bus.taken_o), 32'd0);
    handoff("bltu");
    run(4'b0001, 1'b1, 3'b001, 32'h1, 32'h0, lat);
    chk("bne_taken", 32'(bus.taken_o), 32'd1);
    handoff("bne");
    run(4'b0101, 1'b1, 3'b101, 32'h1, 32'hFFFF_FFFF, lat);
    chk("bge_res", bus.resultado_o, 32'h0);
    chk("bge_taken", 32'(bus.taken_o), 32'd1);
    handoff("bge");
    run(4'b0000, 1'b1, 3'b010, 32'h0, 32'h0, lat);
    chk("ctrl010_taken", 32'(bus.taken_o), 32'd0);
    handoff("ctrl010");
    run(4'b0010, 1'b0, 3'b000, 32'h1, 32'h2, lat);
    chk("nobranch_taken", 32'(bus.taken_o), 32'd0);
    handoff("nobranch");
    run(4'b0000, 1'b0, 3'b000, 32'h0000_F0F0, 32'h0000_FF00, lat);
    chk("and_res", bus.resultado_o, 32'h0000_F000);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus.valid_i = 1'b1;
        bus.aluoperacion_i = 4'b0010;
        bus.a_i = 32'h1;
        bus.b_i = 32'h1;
      end
      if (i == 2) bus.valid_i = 1'b0;
      tick();
      chk("bp_valid", 32'(bus.valid_o), 32'd1);
      chk("bp_ready", 32'(bus.ready_o), 32'd0);
      chk("bp_res", bus.resultado_o, 32'h0000_F000);
    end
    handoff("bp");
    tick();
    chk("bp_no_ghost", 32'(bus.valid_o), 32'd0);
    run(4'b1111, 1'b1, 3'b000, 32'h55, 32'h66, lat);
    chk("unsup_err", 32'(bus.error_o), 32'd1);
    chk("unsup_res", bus.resultado_o, 32'h0);
    chk("unsup_zero", 32'(bus.zero_o), 32'd1);
    chk("unsup_taken", 32'(bus.taken_o), 32'd0);
    handoff("unsup");
    run(4'b0111, 1'b0, 3'b000, 32'h55, 32'h66, lat);
    chk("unsup7_err", 32'(bus.error_o), 32'd1);
    handoff("unsup7");
    run(4'b0010, 1'b0, 3'b000, 32'd2, 32'd3, lat);
    chk("after_err", 32'(bus.error_o), 32'd0);
    chk("after_res", bus.resultado_o, 32'd5);
    bus.ready_i = 1'b1;
    tick();
    run(4'b0010, 1'b0, 3'b000, 32'd4, 32'd4, lat);
    chk("thru_lat", 32'(lat), 32'd0);
    chk("thru_res", bus.resultado_o, 32'd8);
    tick();
    bus.ready_i = 1'b0;
    chk("thru_ready", 32'(bus.ready_o), 32'd1);
    bus.valid_i = 1'b1;
    bus.aluoperacion_i = 4'b1001;
    bus.branch_i = 1'b0;
    bus.a_i = 32'h1;
    bus.b_i = 32'd20;
    tick();
    bus.valid_i = 1'b0;
    repeat (9) tick();
    chk("mid_shift_ready", 32'(bus.ready_o), 32'd0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rst_shift_ready", 32'(bus.ready_o), 32'd1);
    chk("rst_shift_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_shift_res", bus.resultado_o, 32'h0);
    chk("rst_shift_zero", 32'(bus.zero_o), 32'd1);
    bad = 0;
    repeat (30) begin
      tick();
      if (bus.valid_o) bad++;
    end
    chk("no_stale", 32'(bad), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
